// File: rtl/sa_skid_pkg.sv
// Shared types and constants for the sa_skid_pipe valid/ready skid stage.
// The optional stall counter is enabled with SA_SKID_STALL_CNT_EN.
package sa_skid_pkg;

  // state | meaning
  // EMPTY | no word held, out_valid low
  // ONE   | main register holds the head word
  // TWO   | main holds head, skid holds the word behind it, in_ready low
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  localparam int   SA_SKID_CNT_W   = 16;
  localparam logic SA_SKID_RST_BIT = 1'b0;

endpackage

// File: rtl/sa_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sa_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE_STEP = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + ONE_STEP;
    end
  end

endmodule

// File: rtl/sa_skid_pipe.sv
// Registered valid/ready stage with a two-entry skid buffer.
// Define SA_SKID_STALL_CNT_EN to add the stall_clr/stall_cnt stall counter.
module sa_skid_pipe
  import sa_skid_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef SA_SKID_STALL_CNT_EN
  input  logic                     stall_clr,
  output logic [SA_SKID_CNT_W-1:0] stall_cnt,
`endif
  output logic [WIDTH-1:0]         out_data
);

  localparam logic [WIDTH-1:0] RST_DATA = {WIDTH{SA_SKID_RST_BIT}};

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             accept, emit;
  logic             load_main_in, load_main_skid, load_skid;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && emit) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (emit) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs decode the state flops only; out_ready never reaches in_ready.
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = (state_q != TWO) & ~nvdla_core_rst;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      main_q <= RST_DATA;
      skid_q <= RST_DATA;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  assign out_data = main_q;

`ifdef SA_SKID_STALL_CNT_EN
  sa_sat_cnt #(
    .W (SA_SKID_CNT_W)
  ) u_stall_cnt (
    .clk (nvdla_core_clk),
    .rst (nvdla_core_rst),
    .inc (out_valid & ~out_ready),
    .clr (stall_clr),
    .cnt (stall_cnt)
  );
`endif

endmodule
